regread_arbiter: RTL and testbench

Round-robin arbiter sharing the single 4-bit register read port (the 4-to-1 register-select mux) among four requesters. Each requester presents a 2-bit register index. The block grants one requester per cycle, drives the mux select with the granted index, samples the mux output and returns it to the grantee with a one-cycle valid strobe. It sits between the requesters and the register-select mux and is the only driver of that mux's select input.

---
 rtl/regread_arbiter_if.sv | 26 ++
 rtl/regread_arbiter.sv | 72 +++++++
 tb/tb_regread_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/regread_arbiter_if.sv
// rtl/regread_arbiter_if.sv - requester/mux side bundle of the register read-port arbiter
interface regread_arbiter_if #(
   parameter int DW = 4,
   parameter int AW = 2
);
   logic [3:0]      req;
   logic [4*AW-1:0] req_addr;
   logic            stall;
   logic [3:0]      gnt;
   logic [AW-1:0]   src;
   logic [DW-1:0]   rd_data;
   logic [3:0]      rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            busy;

   // master: requesters plus the register mux that drives rd_data from src
   modport master (
      output req, req_addr, stall, rd_data,
      input  gnt, src, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  req, req_addr, stall, rd_data,
      output gnt, src, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/regread_arbiter.sv
// rtl/regread_arbiter.sv - round-robin arbiter for the shared 4-bit register read port
module regread_arbiter #(
   parameter int DW = 4,
   parameter int AW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   regread_arbiter_if.slave bus
);
   localparam int NR = 4;
   localparam int PW = 2;

   logic [NR-1:0] gnt_q;
   logic [NR-1:0] rsp_valid_q;
   logic [AW-1:0] src_q;
   logic [PW-1:0] ptr_q;
   logic [DW-1:0] rsp_data_q;

   logic [NR-1:0] eff;
   logic [NR-1:0] win_oh;
   logic [PW-1:0] win_idx;
   logic [PW-1:0] scan_idx;
   logic [AW-1:0] win_addr;
   logic          win;

   // a requester holding gnt this cycle sits out, so it can win at most every other cycle
   assign eff = bus.req & ~gnt_q;

   always_comb begin
      win      = 1'b0;
      win_idx  = ptr_q;
      scan_idx = ptr_q;
      for (int off = 0; off < NR; off++) begin
         scan_idx = ptr_q + PW'(off);
         if (!win && eff[scan_idx]) begin
            win     = 1'b1;
            win_idx = scan_idx;
         end
      end
      win_oh   = NR'(1) << win_idx;
      win_addr = bus.req_addr[AW*win_idx +: AW];
   end

   // src and ptr move only on a grant edge so the mux select never toggles while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q       <= '0;
         src_q       <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= gnt_q;
         if (|gnt_q) begin
            rsp_data_q <= bus.rd_data;
         end
         if (!bus.stall && win) begin
            gnt_q <= win_oh;
            src_q <= win_addr;
            ptr_q <= win_idx + PW'(1);
         end else begin
            gnt_q <= '0;
         end
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.src       = src_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (|gnt_q) | (|rsp_valid_q);
endmodule

// File: tb/tb_regread_arbiter.sv
// tb/tb_regread_arbiter.sv - directed and randomized bench for regread_arbiter
module tb_regread_arbiter;
   logic clk;
   logic rst_n;
   logic [3:0] regs [4];
   int n_cmp;
   int n_err;

   // reference state: granted requester (-1 none), its index, scan start, response owner
   int m_gnt;
   int m_src;
   int m_ptr;
   int m_rsp;
   logic [3:0] m_rsp_data;
   int waits [4];

   regread_arbiter_if #(.DW(4), .AW(2)) bus ();

   regread_arbiter #(.DW(4), .AW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.rd_data = regs[bus.src];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] onehot(input int k);
      return (k < 0) ? 4'b0000 : (4'b0001 << k);
   endfunction

   task automatic model_reset();
      m_gnt = -1;
      m_src = 0;
      m_ptr = 0;
      m_rsp = -1;
      m_rsp_data = 4'h0;
      for (int i = 0; i < 4; i++) waits[i] = 0;
   endtask

   task automatic check_all();
      chk("gnt", 32'(bus.gnt), 32'(onehot(m_gnt)));
      chk("src", 32'(bus.src), 32'(m_src));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(onehot(m_rsp)));
      chk("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
      chk("busy", 32'(bus.busy), 32'((m_gnt >= 0) || (m_rsp >= 0)));
   endtask

   // advance model and DUT one clock, then compare every output
   task automatic step();
      int w;
      int i;
      int n_rsp;
      logic [3:0] n_data;
      n_rsp  = m_gnt;
      n_data = (m_gnt >= 0) ? regs[m_src] : m_rsp_data;
      w = -1;
      if (!bus.stall) begin
         for (int off = 0; off < 4; off++) begin
            i = (m_ptr + off) % 4;
            if (w < 0 && bus.req[i] && i != m_gnt) w = i;
         end
      end
      if (w >= 0) begin
         m_gnt = w;
         m_src = int'(bus.req_addr[2*w +: 2]);
         m_ptr = (w + 1) % 4;
      end else begin
         m_gnt = -1;
      end
      m_rsp = n_rsp;
      m_rsp_data = n_data;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      bus.req = 4'b0000;
      bus.req_addr = 8'h00;
      bus.stall = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      regs[0] = 4'h3; regs[1] = 4'h5; regs[2] = 4'hA; regs[3] = 4'hC;
      bus.req = 4'b0000;
      bus.req_addr = 8'h00;
      bus.stall = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #12;
      check_all();
      do_reset();
      for (int c = 0; c < 3; c++) step();

      // single read of register 2 by requester 0
      do_reset();
      bus.req = 4'b0001;
      bus.req_addr = 8'b00_00_00_10;
      step();
      chk("single_gnt", 32'(bus.gnt), 32'h1);
      chk("single_src", 32'(bus.src), 32'h2);
      bus.req = 4'b0000;
      step();
      chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("single_rsp_data", 32'(bus.rsp_data), 32'hA);
      step();

      // all four held: grant order 0,1,2,3,0 with data 3,5,A,C
      do_reset();
      bus.req = 4'b1111;
      bus.req_addr = 8'b11_10_01_00;
      for (int c = 0; c < 6; c++) begin
         step();
         if (c < 5) chk("rr_gnt", 32'(bus.gnt), 32'(onehot(c % 4)));
         if (c > 0) begin
            chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(onehot((c - 1) % 4)));
            chk("rr_rsp_data", 32'(bus.rsp_data), 32'(regs[(c - 1) % 4]));
         end
      end
      bus.req = 4'b0000;
      step();
      step();

      // re-request masking: one requester held high for three cycles
      do_reset();
      bus.req = 4'b0001;
      bus.req_addr = 8'h01;
      step(); chk("mask_gnt0", 32'(bus.gnt), 32'h1);
      step(); chk("mask_gnt1", 32'(bus.gnt), 32'h0);
              chk("mask_rsp1", 32'(bus.rsp_valid), 32'h1);
      step(); chk("mask_gnt2", 32'(bus.gnt), 32'h1);
      bus.req = 4'b0000;
      step(); chk("mask_rsp3", 32'(bus.rsp_valid), 32'h1);
              chk("mask_data3", 32'(bus.rsp_data), 32'h5);
      step();

      // stall holds off grants; release gives 1 then 2
      do_reset();
      bus.req = 4'b0110;
      bus.req_addr = 8'b00_11_10_00;
      bus.stall = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("stall_gnt", 32'(bus.gnt), 32'h0);
         chk("stall_src", 32'(bus.src), 32'h0);
      end
      bus.stall = 1'b0;
      step(); chk("unstall_gnt_a", 32'(bus.gnt), 32'h2);
      bus.req = 4'b0100;
      step(); chk("unstall_gnt_b", 32'(bus.gnt), 32'h4);
              chk("unstall_src_b", 32'(bus.src), 32'h3);
      bus.req = 4'b0000;
      step();
      step();

      // stall asserted right after a grant does not cancel its response
      do_reset();
      bus.req = 4'b0001;
      bus.req_addr = 8'h03;
      step(); chk("sag_gnt", 32'(bus.gnt), 32'h1);
      bus.stall = 1'b1;
      step(); chk("sag_rsp_valid", 32'(bus.rsp_valid), 32'h1);
              chk("sag_rsp_data", 32'(bus.rsp_data), 32'hC);
              chk("sag_no_gnt", 32'(bus.gnt), 32'h0);
      step(); chk("sag_no_gnt2", 32'(bus.gnt), 32'h0);
      bus.stall = 1'b0;
      bus.req = 4'b0000;
      step();

      // randomized traffic obeying the hold-until-grant protocol
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            if (bus.gnt[i]) begin
               chk("wait_bound", 32'(waits[i] <= 3), 32'h1);
               waits[i] = 0;
            end else if (bus.req[i] && bus.gnt != 4'b0000) begin
               waits[i]++;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (m_gnt == i) begin
               bus.req[i] = 1'($urandom_range(0, 1));
               bus.req_addr[2*i +: 2] = 2'($urandom_range(0, 3));
            end else if (!bus.req[i]) begin
               bus.req[i] = ($urandom_range(0, 2) == 0);
               bus.req_addr[2*i +: 2] = 2'($urandom_range(0, 3));
            end
         end
         bus.stall = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 3)] = 4'($urandom);
      end

      // asynchronous reset between edges while traffic is in flight
      bus.req = 4'b1111;
      bus.stall = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      bus.req = 4'b0000;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
